// File: rtl/clip_player_if.sv
`default_nettype none
// ============================================================================
// Module      : clip_player_if
// Description : Sequencer <-> clip player signal bundle (clip select,
//               play request, mute, buzzer drive, busy flag, note index).
// Revision    : 1.0 - initial release
// ============================================================================
interface clip_player_if;
    logic [1:0] clip_sel;
    logic       play_req;
    logic       mute;
    logic       buzz;
    logic       AOUT;
    logic [1:0] note_idx;

    modport master (
        output clip_sel,
        output play_req,
        output mute,
        input  buzz,
        input  AOUT,
        input  note_idx
    );

    modport slave (
        input  clip_sel,
        input  play_req,
        input  mute,
        output buzz,
        output AOUT,
        output note_idx
    );
endinterface
`default_nettype wire

// File: rtl/clip_player.sv
`default_nettype none
// ============================================================================
// Module      : clip_player
// Description : Plays a 4-note ROM melody as a square wave on a buzzer;
//               AOUT is low while a clip (plus silent tail) is playing.
// Revision    : 1.0 - initial release
// ============================================================================
module clip_player #(
    parameter int NOTE_CYC   = 20000000,
    parameter int GAP_CYC    = 5000000,
    parameter int HALF_SHIFT = 0
) (
    input  wire logic       CLK,
    input  wire logic       RST_N,
    clip_player_if.slave    bus
);

    localparam logic [24:0] NOTE_LAST = 25'(NOTE_CYC - 1);
    localparam logic [24:0] GAP_LAST  = 25'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic        aout_q,     aout_d;
    logic        buzz_q,     buzz_d;
    logic        tgl_q,      tgl_d;
    logic [1:0]  note_idx_q, note_idx_d;
    logic [1:0]  clip_q,     clip_d;
    logic [1:0]  sel_q,      sel_d;
    logic        armed_q,    armed_d;
    logic [24:0] timer_q,    timer_d;
    logic [17:0] tone_q,     tone_d;

    logic        sel_chg;
    logic        trig;
    logic        restart;
    logic [2:0]  cur_code;
    logic [17:0] cur_half;

    function automatic logic [2:0] note_code(input logic [1:0] clip,
                                             input logic [1:0] idx);
        logic [2:0] code;
        case ({clip, idx})
            4'b00_00: code = 3'd1;  4'b00_01: code = 3'd3;
            4'b00_10: code = 3'd5;  4'b00_11: code = 3'd0;
            4'b01_00: code = 3'd3;  4'b01_01: code = 3'd5;
            4'b01_10: code = 3'd7;  4'b01_11: code = 3'd0;
            4'b10_00: code = 3'd2;  4'b10_01: code = 3'd4;
            4'b10_10: code = 3'd6;  4'b10_11: code = 3'd0;
            4'b11_00: code = 3'd5;  4'b11_01: code = 3'd6;
            4'b11_10: code = 3'd7;  default:  code = 3'd7;
        endcase
        return code;
    endfunction

    function automatic logic [17:0] half_of(input logic [2:0] code);
        logic [17:0] base;
        case (code)
            3'd1:    base = 18'd190840;
            3'd2:    base = 18'd170068;
            3'd3:    base = 18'd151515;
            3'd4:    base = 18'd143266;
            3'd5:    base = 18'd127551;
            3'd6:    base = 18'd113636;
            3'd7:    base = 18'd101215;
            default: base = 18'd0;
        endcase
        return base >> HALF_SHIFT;
    endfunction

    // Nothing can trigger until armed, which masks the sel_q=0 reset value.
    assign sel_chg  = (bus.clip_sel != sel_q);
    assign trig     = armed_q & (bus.play_req | sel_chg);
    assign restart  = (state_q == S_IDLE) ? trig : (armed_q & sel_chg);
    assign cur_code = note_code(clip_q, note_idx_q);
    assign cur_half = half_of(cur_code);

    always_comb begin
        state_d    = state_q;
        aout_d     = aout_q;
        tgl_d      = tgl_q;
        note_idx_d = note_idx_q;
        clip_d     = clip_q;
        sel_d      = bus.clip_sel;
        armed_d    = 1'b1;
        timer_d    = timer_q;
        tone_d     = tone_q;

        case (state_q)
            S_PLAY: begin
                if (timer_q == NOTE_LAST) begin
                    timer_d = '0;
                    tone_d  = '0;
                    tgl_d   = 1'b0;
                    if (note_idx_q == 2'd3) begin
                        state_d = S_GAP;
                    end else begin
                        note_idx_d = note_idx_q + 2'd1;
                    end
                end else begin
                    timer_d = timer_q + 25'd1;
                    if (cur_code == 3'd0) begin
                        tgl_d  = 1'b0;
                        tone_d = '0;
                    end else if (tone_q == cur_half - 18'd1) begin
                        tgl_d  = ~tgl_q;
                        tone_d = '0;
                    end else begin
                        tone_d = tone_q + 18'd1;
                    end
                end
            end
            S_GAP: begin
                tgl_d = 1'b0;
                if (timer_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    aout_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 25'd1;
                end
            end
            default: begin
                aout_d = 1'b1;
                tgl_d  = 1'b0;
            end
        endcase

        if (restart) begin
            state_d    = S_PLAY;
            clip_d     = bus.clip_sel;
            note_idx_d = 2'd0;
            timer_d    = '0;
            tone_d     = '0;
            tgl_d      = 1'b0;
            aout_d     = 1'b0;
        end

        // Mute only masks the output; tgl keeps its phase underneath.
        buzz_d = tgl_d & ~bus.mute;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            aout_q     <= 1'b1;
            buzz_q     <= 1'b0;
            tgl_q      <= 1'b0;
            note_idx_q <= 2'd0;
            clip_q     <= 2'd0;
            sel_q      <= 2'd0;
            armed_q    <= 1'b0;
            timer_q    <= '0;
            tone_q     <= '0;
        end else begin
            state_q    <= state_d;
            aout_q     <= aout_d;
            buzz_q     <= buzz_d;
            tgl_q      <= tgl_d;
            note_idx_q <= note_idx_d;
            clip_q     <= clip_d;
            sel_q      <= sel_d;
            armed_q    <= armed_d;
            timer_q    <= timer_d;
            tone_q     <= tone_d;
        end
    end

    assign bus.buzz     = buzz_q;
    assign bus.AOUT     = aout_q;
    assign bus.note_idx = note_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_clip_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_clip_player
// Description : Self-checking bench for clip_player with scaled-down timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clip_player;

    localparam int NC   = 2000;
    localparam int GC   = 500;
    localparam int BUSY = 4 * NC + GC;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    clip_player_if bus ();

    clip_player #(
        .NOTE_CYC   (NC),
        .GAP_CYC    (GC),
        .HALF_SHIFT (10)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] clip;
        int         h0, h1, h2, h3;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge of busy offset 0.
    task automatic start_play(input logic [1:0] c, input bit req, input string tag);
        check($sformatf("%s idle before trigger", tag), {31'd0, bus.AOUT}, 32'd1);
        bus.clip_sel = c;
        bus.play_req = req;
        @(negedge clk);
        bus.play_req = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the expected square wave.
    task automatic check_play(input int h0, input int h1, input int h2, input int h3,
                              input int ncyc, input bit end_chk,
                              input int mlo, input int mhi, input int req_at,
                              input string tag);
        int be = 0, ie = 0, ae = 0;
        int bf = -1, idf = -1, af = -1;
        for (int t = 0; t < ncyc; t++) begin
            int nt, off, h;
            logic eb;
            logic [1:0] ei;
            if (t >= 4 * NC) begin
                eb = 1'b0;
                ei = 2'd3;
            end else begin
                nt  = t / NC;
                off = t % NC;
                case (nt)
                    0:       h = h0;
                    1:       h = h1;
                    2:       h = h2;
                    default: h = h3;
                endcase
                ei = nt[1:0];
                eb = (h == 0) ? 1'b0 : (((off / h) % 2) == 1);
            end
            if (t >= mlo && t < mhi) eb = 1'b0;
            if (bus.buzz !== eb)     begin if (be == 0) bf  = t; be++; end
            if (bus.note_idx !== ei) begin if (ie == 0) idf = t; ie++; end
            if (bus.AOUT !== 1'b0)   begin if (ae == 0) af  = t; ae++; end
            if (t == mlo - 1)    bus.mute     = 1'b1;
            if (t == mhi - 1)    bus.mute     = 1'b0;
            if (t == req_at - 1) bus.play_req = 1'b1;
            if (t == req_at)     bus.play_req = 1'b0;
            @(negedge clk);
        end
        check($sformatf("%s buzz wave errors (first at %0d)", tag, bf), be, 0);
        check($sformatf("%s note_idx errors (first at %0d)", tag, idf), ie, 0);
        check($sformatf("%s AOUT busy errors (first at %0d)", tag, af), ae, 0);
        if (end_chk) begin
            check($sformatf("%s AOUT high after window", tag), {31'd0, bus.AOUT}, 32'd1);
            check($sformatf("%s buzz low after window", tag), {31'd0, bus.buzz}, 32'd0);
        end
    endtask

    initial begin
        int err;
        tests = 0;
        fails = 0;

        vecs[0] = '{clip: 2'd0, h0: 186, h1: 147, h2: 124, h3: 0};
        vecs[1] = '{clip: 2'd1, h0: 147, h1: 124, h2: 98,  h3: 0};
        vecs[2] = '{clip: 2'd2, h0: 166, h1: 139, h2: 110, h3: 0};
        vecs[3] = '{clip: 2'd3, h0: 124, h1: 110, h2: 98,  h3: 98};

        rst_n        = 1'b0;
        bus.clip_sel = 2'd2;
        bus.play_req = 1'b0;
        bus.mute     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset AOUT", {31'd0, bus.AOUT}, 32'd1);
        check("reset buzz", {31'd0, bus.buzz}, 32'd0);
        check("reset note_idx", {30'd0, bus.note_idx}, 32'd0);

        // Release with clip_sel != reset sel_q: must not trigger.
        rst_n = 1'b1;
        err = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.AOUT !== 1'b1 || bus.buzz !== 1'b0) err++;
        end
        check("reset release no spurious trigger", err, 0);

        for (int v = 0; v < 4; v++) begin
            start_play(vecs[v].clip, 1'b1, $sformatf("clip%0d", v));
            check_play(vecs[v].h0, vecs[v].h1, vecs[v].h2, vecs[v].h3,
                       BUSY, 1'b1, -1, -1, -1, $sformatf("clip%0d", v));
        end

        // Clip change during note 1 restarts with the new clip.
        start_play(2'd0, 1'b1, "restart");
        check_play(186, 147, 124, 0, 2700, 1'b0, -1, -1, -1, "restart pre");
        check("restart pre note_idx", {30'd0, bus.note_idx}, 32'd1);
        check("restart pre AOUT", {31'd0, bus.AOUT}, 32'd0);
        bus.clip_sel = 2'd3;
        @(negedge clk);
        check_play(124, 110, 98, 98, BUSY, 1'b1, -1, -1, -1, "restart post");

        // play_req with an unchanged clip_sel while busy is ignored.
        start_play(2'd0, 1'b1, "ignored");
        check_play(186, 147, 124, 0, BUSY, 1'b1, -1, -1, 3000, "ignored req");

        // Mute across part of note 0, released mid-note.
        start_play(2'd1, 1'b1, "mute");
        check_play(147, 124, 98, 0, BUSY, 1'b1, 50, 400, -1, "mute");

        // Asynchronous reset during the silent tail.
        start_play(2'd2, 1'b1, "rstgap");
        check_play(166, 139, 110, 0, 8200, 1'b0, -1, -1, -1, "rstgap");
        #2 rst_n = 1'b0;
        #1;
        check("async reset AOUT", {31'd0, bus.AOUT}, 32'd1);
        check("async reset buzz", {31'd0, bus.buzz}, 32'd0);
        check("async reset note_idx", {30'd0, bus.note_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        err = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.AOUT !== 1'b1 || bus.buzz !== 1'b0) err++;
        end
        check("idle after async reset", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
